im_loader: RTL
==============

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port Clr  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  single-cycle load request.
REQ-004 SHALL have port byte_in  input  8  boot stream byte.
REQ-005 SHALL have port byte_valid  input  1  byte_in holds a byte.
REQ-006 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port we  output  1  instruction-memory write strobe.
REQ-008 SHALL have port waddr  output  11  instruction-memory word index.
REQ-009 SHALL have port wdata  output  32  instruction word to write.
REQ-010 SHALL have port hold  output  1  stall to fetch unit while loading.
REQ-011 SHALL have port done  output  1  load complete.
REQ-012 SHALL have port err  output  1  checksum mismatch.

Function
REQ-013 SHALL transfer a byte only on a cycle with byte_valid=1 and byte_ready=1.
REQ-014 SHALL use states IDLE, CNT_HI, CNT_LO, DATA, WRITE, CKSUM, DONE.
REQ-015 SHALL move IDLE or DONE -> CNT_HI on start=1, clear done and err, and set hold=1; start SHALL be ignored in all other states.
REQ-016 SHALL take a 16-bit word count, MSB first: CNT_HI -> CNT_LO -> DATA.
REQ-017 SHALL move directly from CNT_LO to CKSUM (macro on) or to DONE (macro off) when count=0.
REQ-018 SHALL assemble each word from 4 bytes, MSB first.
REQ-019 SHALL enter WRITE on the cycle after the 4th byte is accepted, and assert we=1 with wdata and waddr stable for exactly that one cycle.
REQ-020 SHALL hold byte_ready=1 in CNT_HI, CNT_LO, DATA and CKSUM, and 0 in IDLE, WRITE and DONE.
REQ-021 SHALL start waddr at 0, the index of byte address 32'h00003000 under mapping {~A[12],A[11:2]}.
REQ-022 SHALL increment waddr by 1 after each write, wrapping 2047 -> 0; counts above 2048 overwrite from index 0.
REQ-023 SHALL go WRITE -> DATA while words remain, otherwise to CKSUM (macro on) or DONE (macro off).
REQ-024 SHALL drive done=1 and hold=0 in DONE and remain there until the next start.
REQ-025 SHALL keep hold=1 from the start cycle through the final WRITE or CKSUM cycle.

Reset
REQ-026 SHALL, on Clr=1 in any state including mid-load, enter IDLE with byte_ready=0, we=0, waddr=0, wdata=0, hold=0, done=0 and err=0.
REQ-027 SHALL discard any partial word and the remaining count on Clr.

Configuration
REQ-028 SHALL, with IM_LOADER_CKSUM_EN defined, accept one trailing byte in CKSUM, compare it with the XOR of all data bytes (count bytes excluded, 0x00 when count=0), set err=1 on mismatch, then enter DONE.
REQ-029 SHALL, without IM_LOADER_CKSUM_EN, omit the CKSUM state and tie err to 0.

Structure
REQ-030 SHALL define the state enum, the IM depth constant (2048) and the base-address constant (32'h00003000) in shared package cpu_pkg.
REQ-031 SHALL place byte-to-word assembly (shift register plus 2-bit byte counter) in sub-module word_asm.

Verification
REQ-032 SHALL cover: start; bytes 00 01 DE AD BE EF -> one we pulse with waddr=0 and wdata=32'hDEADBEEF on the cycle after EF is accepted, then done=1 and hold=0.
REQ-033 SHALL cover: count 3 with byte_valid toggled every other cycle -> writes at waddr 0,1,2 in order, byte_ready=0 during each WRITE, no bytes lost.
REQ-034 SHALL cover: Clr asserted after 2 data bytes -> next cycle in IDLE with all outputs 0; a fresh start then loads correctly from waddr 0.
REQ-035 SHALL cover: count 0 -> no we pulse; done=1 (macro off) or after one checksum byte (macro on).
REQ-036 SHALL cover, with macro on: words 0x11223344 and a checksum byte of 0x44 -> err=0; the same words with 0x45 -> err=1, done=1.
REQ-037 SHALL cover: count 2049 -> the last word is written at waddr 0 and overwrites the first.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared loader state encoding and instruction-memory geometry.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    CKSUM,
    DONE
  } state_t;

  localparam int          IM_DEPTH = 2048;
  localparam int          IM_AW    = $clog2(IM_DEPTH);
  localparam logic [31:0] IM_BASE  = 32'h00003000;

  // Byte address to IM word index: the base region lands on index 0.
  function automatic logic [IM_AW-1:0] im_index(input logic [31:0] addr);
    return {~addr[12], addr[11:2]};
  endfunction

endpackage

// File: rtl/word_asm.sv
// Collects four boot-stream bytes, MSB first, into one 32-bit instruction word.
module word_asm (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift) begin
      word <= {word[23:0], byte_in};
      cnt  <= cnt + 2'd1;
    end
  end

  // High while the next accepted byte completes the word.
  assign last = (cnt == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Boot-stream loader: 16-bit word count, then 4-byte words written to IM.
// Define IM_LOADER_CKSUM_EN to check a trailing XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for start after reset
// CNT_HI | taking word-count high byte
// CNT_LO | taking word-count low byte
// DATA   | taking instruction bytes
// WRITE  | one-cycle IM write strobe
// CKSUM  | taking the checksum byte
// DONE   | load finished, fetch released
module im_loader
  import cpu_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 we,
  output logic [IM_AW-1:0]     waddr,
  output logic [31:0]          wdata,
  output logic                 hold,
  output logic                 done,
  output logic                 err
);

`ifdef IM_LOADER_CKSUM_EN
  localparam state_t AFTER_LOAD = CKSUM;
`else
  localparam state_t AFTER_LOAD = DONE;
`endif

  state_t      state, state_nx;
  logic [7:0]  cnt_hi;
  logic [15:0] words_left;
  logic        accept, start_ok, last;

  assign byte_ready = (state == CNT_HI) || (state == CNT_LO) ||
                      (state == DATA)   || (state == CKSUM);
  assign accept     = byte_valid && byte_ready;
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign we         = (state == WRITE);
  assign hold       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = CNT_HI;
      CNT_HI:     if (accept) state_nx = CNT_LO;
      CNT_LO:     if (accept) state_nx = ({cnt_hi, byte_in} == 16'd0) ? AFTER_LOAD : DATA;
      DATA:       if (accept && last) state_nx = WRITE;
      WRITE:      state_nx = (words_left == 16'd1) ? AFTER_LOAD : DATA;
      CKSUM:      if (accept) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state      <= IDLE;
      cnt_hi     <= '0;
      words_left <= '0;
      waddr      <= im_index(IM_BASE);
    end else begin
      state <= state_nx;
      if (start_ok) waddr <= im_index(IM_BASE);
      if (accept && (state == CNT_HI)) cnt_hi <= byte_in;
      if (accept && (state == CNT_LO)) words_left <= {cnt_hi, byte_in};
      if (state == WRITE) begin
        waddr      <= waddr + 1'b1;
        words_left <= words_left - 16'd1;
      end
    end
  end

`ifdef IM_LOADER_CKSUM_EN
  logic [7:0] xsum;
  logic       err_q;

  always_ff @(posedge Clk) begin
    if (Clr || start_ok) begin
      xsum  <= '0;
      err_q <= 1'b0;
    end else if (accept && (state == DATA)) begin
      xsum <= xsum ^ byte_in;
    end else if (accept && (state == CKSUM)) begin
      err_q <= (byte_in != xsum);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  word_asm u_word_asm (
    .clk     (Clk),
    .clr     (Clr),
    .flush   (start_ok),
    .shift   (accept && (state == DATA)),
    .byte_in (byte_in),
    .word    (wdata),
    .last    (last)
  );

endmodule
